// File: rtl/preif_pc_gen_pkg.sv
// Shared definitions for the pre-IF PC generator: default geometry, FSM
// encoding and fetch-block size/alignment helpers.
package preif_pc_gen_pkg;

  localparam int          PREIF_PC_W     = 32;
  localparam logic [31:0] PREIF_RESET_PC = 32'h1c00_0000;
  localparam int          PREIF_FETCH_N  = 1;

  // state    | meaning
  // ST_RST   | first cycle after reset, no request
  // ST_STALL | no request; redirects load fetch_pc directly
  // ST_REQ   | request raised, address held until addr_ok
  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_STALL = 2'd1,
    ST_REQ   = 2'd2
  } preif_state_e;

  // Address bits below the fetch-block boundary (4-byte instructions).
  function automatic int preif_align_bits(input int fetch_n);
    return (fetch_n == 4) ? 4 : (fetch_n == 2) ? 3 : 2;
  endfunction

  function automatic int preif_block_bytes(input int fetch_n);
    return 4 * fetch_n;
  endfunction

  localparam int          PREIF_BLOCK_BYTES = preif_block_bytes(PREIF_FETCH_N);
  localparam logic [31:0] PREIF_ALIGN_MASK  = 32'hFFFF_FFFF << preif_align_bits(PREIF_FETCH_N);

endpackage

// File: rtl/preif_pc_gen_redirect_buf.sv
// Redirect source priority and the one-entry buffer that remembers a
// redirect seen while a request is still waiting for addr_ok.
// Optional feature macro: PREIF_EXCP_EN (exception/ertn redirect input).
module preif_redirect_buf
  import preif_pc_gen_pkg::*;
#(
  parameter int PC_W = PREIF_PC_W
) (
  input  logic            clk,
  input  logic            rst,
`ifdef PREIF_EXCP_EN
  input  logic            excp_valid_i,
  input  logic [PC_W-1:0] excp_pc_i,
`endif
  input  logic            br_valid_i,
  input  logic [PC_W-1:0] br_pc_i,
  input  logic            capture_i,
  input  logic            clear_i,
  output logic            redir_o,
  output logic [PC_W-1:0] redir_pc_o,
  output logic            pend_valid_o,
  output logic [PC_W-1:0] pend_pc_o
);

  logic            pend_valid_q, pend_valid_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;

  // Merge redirect sources; exception wins over a same-cycle branch.
  always_comb begin
`ifdef PREIF_EXCP_EN
    redir_o    = excp_valid_i | br_valid_i;
    redir_pc_o = excp_valid_i ? excp_pc_i : br_pc_i;
`else
    redir_o    = br_valid_i;
    redir_pc_o = br_pc_i;
`endif
  end

  // Next pending entry: acceptance empties it, a newer redirect overwrites it.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    if (clear_i) begin
      pend_valid_d = 1'b0;
    end else if (capture_i && redir_o) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = redir_pc_o;
    end
  end

  // Pending redirect register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  assign pend_valid_o = pend_valid_q;
  assign pend_pc_o    = pend_pc_q;

endmodule

// File: rtl/preif_pc_gen.sv
// Pre-IF stage: fetch PC register, instruction-SRAM request handshake and
// hand-off of accepted fetches to IF, with in-flight redirect handling.
// Optional feature macro: PREIF_EXCP_EN adds the exception redirect port.
module preif_pc_gen
  import preif_pc_gen_pkg::*;
#(
  parameter int              PC_W     = PREIF_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(PREIF_RESET_PC),
  parameter int              FETCH_N  = PREIF_FETCH_N
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_valid_i,
  input  logic [PC_W-1:0] br_pc_i,
`ifdef PREIF_EXCP_EN
  input  logic            excp_valid_i,
  input  logic [PC_W-1:0] excp_pc_i,
`endif
  input  logic            if_allowin_i,
  output logic            inst_req_o,
  output logic [PC_W-1:0] inst_addr_o,
  input  logic            inst_addr_ok_i,
  output logic            preif_to_if_valid_o,
  output logic [PC_W-1:0] preif_to_if_pc_o,
  output logic            preif_to_if_drop_o
);

  localparam int              ALIGN_BITS  = preif_align_bits(FETCH_N);
  localparam logic [PC_W-1:0] ALIGN_MASK  = {PC_W{1'b1}} << ALIGN_BITS;
  localparam logic [PC_W-1:0] BLOCK_BYTES = PC_W'(preif_block_bytes(FETCH_N));

  preif_state_e    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] aligned_pc, seq_pc;
  logic            accept;
  logic            redir;
  logic [PC_W-1:0] redir_pc;
  logic            pend_valid;
  logic [PC_W-1:0] pend_pc;

  assign aligned_pc = fetch_pc_q & ALIGN_MASK;
  assign seq_pc     = aligned_pc + BLOCK_BYTES;
  assign accept     = (state_q == ST_REQ) && inst_addr_ok_i;

  preif_redirect_buf #(
    .PC_W (PC_W)
  ) u_redirect_buf (
    .clk          (clk),
    .rst          (rst),
`ifdef PREIF_EXCP_EN
    .excp_valid_i (excp_valid_i),
    .excp_pc_i    (excp_pc_i),
`endif
    .br_valid_i   (br_valid_i),
    .br_pc_i      (br_pc_i),
    .capture_i    ((state_q == ST_REQ) && !inst_addr_ok_i),
    .clear_i      (accept),
    .redir_o      (redir),
    .redir_pc_o   (redir_pc),
    .pend_valid_o (pend_valid),
    .pend_pc_o    (pend_pc)
  );

  // State and fetch PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RST;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Next state: an outstanding request is never withdrawn before addr_ok.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RST:   state_d = if_allowin_i ? ST_REQ : ST_STALL;
      ST_STALL: if (if_allowin_i) state_d = ST_REQ;
      ST_REQ:   if (inst_addr_ok_i) state_d = if_allowin_i ? ST_REQ : ST_STALL;
      default:  state_d = ST_RST;
    endcase
  end

  // Next fetch PC: idle redirects load directly, busy ones wait for acceptance.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      ST_RST, ST_STALL: if (redir) fetch_pc_d = redir_pc;
      ST_REQ: begin
        if (inst_addr_ok_i) begin
          fetch_pc_d = redir ? redir_pc : pend_valid ? pend_pc : seq_pc;
        end
      end
      default: fetch_pc_d = fetch_pc_q;
    endcase
  end

  // Outputs: request/address from state, IF hand-off only on acceptance.
  always_comb begin
    inst_req_o          = (state_q == ST_REQ);
    inst_addr_o         = aligned_pc;
    preif_to_if_valid_o = accept;
    preif_to_if_pc_o    = accept ? fetch_pc_q : '0;
    preif_to_if_drop_o  = accept && (pend_valid || redir);
  end

endmodule

// File: tb/tb_preif_pc_gen.sv
module tb_preif_pc_gen;

  logic        clk;
  logic        rst;

  logic        br1, allow1, ok1;
  logic [31:0] br_pc1;
  logic        req1, valid1, drop1;
  logic [31:0] addr1, pc1;

  logic        br4, allow4, ok4;
  logic [31:0] br_pc4;
  logic        req4, valid4, drop4;
  logic [31:0] addr4, pc4;

  logic        excp1, excp4;
  logic [31:0] excp_pc1, excp_pc4;

  int n_tests;
  int n_fail;

  preif_pc_gen #(.PC_W(32), .RESET_PC(32'h1c00_0000), .FETCH_N(1)) u_dut1 (
    .clk                 (clk),
    .rst                 (rst),
    .br_valid_i          (br1),
    .br_pc_i             (br_pc1),
`ifdef PREIF_EXCP_EN
    .excp_valid_i        (excp1),
    .excp_pc_i           (excp_pc1),
`endif
    .if_allowin_i        (allow1),
    .inst_req_o          (req1),
    .inst_addr_o         (addr1),
    .inst_addr_ok_i      (ok1),
    .preif_to_if_valid_o (valid1),
    .preif_to_if_pc_o    (pc1),
    .preif_to_if_drop_o  (drop1)
  );

  preif_pc_gen #(.PC_W(32), .RESET_PC(32'h1c00_0000), .FETCH_N(4)) u_dut4 (
    .clk                 (clk),
    .rst                 (rst),
    .br_valid_i          (br4),
    .br_pc_i             (br_pc4),
`ifdef PREIF_EXCP_EN
    .excp_valid_i        (excp4),
    .excp_pc_i           (excp_pc4),
`endif
    .if_allowin_i        (allow4),
    .inst_req_o          (req4),
    .inst_addr_o         (addr4),
    .inst_addr_ok_i      (ok4),
    .preif_to_if_valid_o (valid4),
    .preif_to_if_pc_o    (pc4),
    .preif_to_if_drop_o  (drop4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b, required %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, required %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    br1 = 1'b0; br_pc1 = '0; allow1 = 1'b1; ok1 = 1'b1;
    br4 = 1'b0; br_pc4 = '0; allow4 = 1'b0; ok4 = 1'b0;
    excp1 = 1'b0; excp_pc1 = '0; excp4 = 1'b0; excp_pc4 = '0;

    // reset state
    step(); step();
    chk1 ("rst_req",   req1,   1'b0);
    chk1 ("rst_valid", valid1, 1'b0);
    chk1 ("rst_drop",  drop1,  1'b0);
    chk32("rst_pc",    pc1,    32'h0);
    chk32("rst_addr1", addr1,  32'h1c00_0000);
    chk32("rst_addr4", addr4,  32'h1c00_0000);

    // zero-wait sequential fetch, FETCH_N=1
    rst = 1'b0;
    step();
    chk1 ("seq0_req",   req1,   1'b1);
    chk32("seq0_addr",  addr1,  32'h1c00_0000);
    chk1 ("seq0_valid", valid1, 1'b1);
    chk32("seq0_pc",    pc1,    32'h1c00_0000);
    chk1 ("seq0_drop",  drop1,  1'b0);
    step();
    chk32("seq1_addr",  addr1,  32'h1c00_0004);
    step();
    chk32("seq2_addr",  addr1,  32'h1c00_0008);
    chk1 ("seq2_drop",  drop1,  1'b0);
    chk1 ("stall4_req", req4,   1'b0);

    // branch on accepted cycle to top of address space, then wrap
    br1 = 1'b1; br_pc1 = 32'hFFFF_FFFC;
    #1;
    chk1 ("brq_drop",  drop1, 1'b1);
    chk32("brq_pc",    pc1,   32'h1c00_0008);
    step();
    br1 = 1'b0;
    #1;
    chk32("wrap_top",  addr1, 32'hFFFF_FFFC);
    chk1 ("wrap_drop", drop1, 1'b0);
    step();
    chk32("wrap_zero", addr1, 32'h0000_0000);
    step();
    chk32("wrap_four", addr1, 32'h0000_0004);

    // held request, branch in wait cycle 1
    ok1 = 1'b0; br1 = 1'b1; br_pc1 = 32'h1c00_0200;
    #1;
    chk1 ("hold1_req",   req1,   1'b1);
    chk1 ("hold1_valid", valid1, 1'b0);
    chk32("hold1_addr",  addr1,  32'h0000_0004);
    step();
    br1 = 1'b0;
    #1;
    chk32("hold2_addr",  addr1,  32'h0000_0004);
    chk1 ("hold2_valid", valid1, 1'b0);
    step();
    ok1 = 1'b1;
    #1;
    chk1 ("hold3_valid", valid1, 1'b1);
    chk32("hold3_pc",    pc1,    32'h0000_0004);
    chk1 ("hold3_drop",  drop1,  1'b1);
    step();
    chk32("redir_addr",  addr1,  32'h1c00_0200);
    chk1 ("redir_drop",  drop1,  1'b0);

    // if_allowin falls while a request is outstanding
    step();
    ok1 = 1'b0; allow1 = 1'b0;
    #1;
    chk32("alw_addr0", addr1,  32'h1c00_0204);
    chk1 ("alw_req0",  req1,   1'b1);
    step();
    chk1 ("alw_req1",  req1,   1'b1);
    chk32("alw_addr1", addr1,  32'h1c00_0204);
    ok1 = 1'b1;
    #1;
    chk1 ("alw_valid", valid1, 1'b1);
    chk32("alw_pc",    pc1,    32'h1c00_0204);
    step();
    chk1 ("alw_stall",  req1,   1'b0);
    chk1 ("alw_svalid", valid1, 1'b0);
    chk32("alw_saddr",  addr1,  32'h1c00_0208);
    step();
    chk1 ("alw_stall2", req1,   1'b0);
    allow1 = 1'b1;
    step();
    chk1 ("alw_resume", req1,   1'b1);
    chk32("alw_raddr",  addr1,  32'h1c00_0208);
    ok1 = 1'b0;

    // FETCH_N=4: branch while stalled, then block-aligned sequential
    br4 = 1'b1; br_pc4 = 32'h1c00_0124; allow4 = 1'b1;
    step();
    br4 = 1'b0; ok4 = 1'b1;
    #1;
    chk1 ("n4_req",   req4,   1'b1);
    chk32("n4_addr",  addr4,  32'h1c00_0120);
    chk32("n4_pc",    pc4,    32'h1c00_0124);
    chk1 ("n4_valid", valid4, 1'b1);
    chk1 ("n4_drop",  drop4,  1'b0);
    step();
    chk32("n4_next",  addr4,  32'h1c00_0130);
    chk32("n4_npc",   pc4,    32'h1c00_0130);

    // branch with simultaneous exception (exception only exists with the macro)
    br4 = 1'b1; br_pc4 = 32'h1c00_0400;
    excp4 = 1'b1; excp_pc4 = 32'h1c00_8000;
    #1;
    chk1 ("prio_drop", drop4, 1'b1);
    step();
    br4 = 1'b0; excp4 = 1'b0;
    #1;
`ifdef PREIF_EXCP_EN
    chk32("prio_addr", addr4, 32'h1c00_8000);
`else
    chk32("prio_addr", addr4, 32'h1c00_0400);
`endif

    // reset in the middle of a held request with a pending redirect
    br1 = 1'b1; br_pc1 = 32'h1234_0000;
    #1;
    chk1 ("mid_req",   req1,   1'b1);
    chk32("mid_addr",  addr1,  32'h1c00_0208);
    step();
    br1 = 1'b0; rst = 1'b1;
    step();
    chk1 ("mid_rreq",  req1,   1'b0);
    chk1 ("mid_rval",  valid1, 1'b0);
    chk32("mid_raddr", addr1,  32'h1c00_0000);
    rst = 1'b0; ok1 = 1'b1;
    step();
    chk1 ("mid_req2",  req1,   1'b1);
    chk32("mid_addr2", addr1,  32'h1c00_0000);
    chk1 ("mid_val2",  valid1, 1'b1);
    chk1 ("mid_drop2", drop1,  1'b0);
    step();
    chk32("mid_addr3", addr1,  32'h1c00_0004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/preif_pc_gen.md
# preif_pc_gen

Parametrised pre-IF stage of the in-order pipeline: owns the fetch PC register, generates instruction-SRAM requests with a valid/addr_ok handshake, and hands each accepted fetch address to IF. Supports multi-instruction fetch blocks, branch (and optionally exception) redirects, and redirects that arrive while a request is still outstanding. It sits between the ID/WB redirect sources and the IF stage.

## Interface
- PC_W, 32, PC / address width
- RESET_PC, 32'h1c00_0000, first fetch address after reset
- FETCH_N, 1, instructions per fetch block; 1, 2 or 4
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- br_valid_i  in  1  branch redirect pulse from ID
- br_pc_i  in  PC_W  branch target
- excp_valid_i  in  1  exception/ertn redirect pulse (PREIF_EXCP_EN only)
- excp_pc_i  in  PC_W  exception target (PREIF_EXCP_EN only)
- if_allowin_i  in  1  IF can take a new fetch; gates launching requests only
- inst_req_o  out  1  instruction-SRAM request
- inst_addr_o  out  PC_W  block-aligned fetch address
- inst_addr_ok_i  in  1  SRAM accepted the request
- preif_to_if_valid_o  out  1  one accepted fetch handed to IF this cycle
- preif_to_if_pc_o  out  PC_W  unaligned PC of the handed fetch
- preif_to_if_drop_o  out  1  handed fetch is wrong-path; IF discards its data

## Operation
- Registers: fetch_pc, FSM state, pend_valid/pend_pc (buffered redirect).
- Redirect this cycle: redir = excp_valid_i | br_valid_i; redir_pc = exception target if excp_valid_i, else br_pc_i.
- inst_addr_o = fetch_pc with low log2(FETCH_N)+2 bits cleared; sequential next = aligned fetch_pc + 4*FETCH_N (mod 2^PC_W, wraps silently).
- States: RST (first cycle after reset), STALL (req low), REQ (req high).
- RST: req low; next state REQ if if_allowin_i, else STALL.
- STALL: req low; redir loads fetch_pc directly (no drop); when if_allowin_i -> REQ.
- REQ: req high; inst_addr_o held stable until accepted (never changes or drops while inst_addr_ok_i low), even if if_allowin_i falls.
- REQ without addr_ok: redir captured into pend_valid/pend_pc; a later redir overwrites it.
- REQ with addr_ok (acceptance): preif_to_if_valid_o=1, pc=fetch_pc, drop = pend_valid | redir. fetch_pc <= redir ? redir_pc : pend_valid ? pend_pc : sequential next. pend_valid cleared. Next state REQ if if_allowin_i else STALL.
- IF contract: IF always takes a handed fetch (one-entry slack); if_allowin_i only prevents new requests.

## Timing
- Reset values: inst_req_o=0, preif_to_if_valid_o=0, preif_to_if_drop_o=0, preif_to_if_pc_o=0, inst_addr_o=aligned RESET_PC, pend_valid=0, state=RST.
- First request earliest in cycle 2 after rst deasserts (RST cycle, then REQ).
- Zero-wait SRAM (addr_ok with req): one accepted fetch per cycle, back-to-back.
- Redirect in STALL at cycle t: request to redir_pc at t+1 if if_allowin_i.
- Redirect in REQ at cycle t (accepted at t or later): stale fetch handed with drop=1 on acceptance; redirected request issued next cycle.
- rst asserted mid-request: request abandoned, outputs return to reset values next edge; pending redirect lost.

## Configuration
- PREIF_EXCP_EN defined: excp_valid_i/excp_pc_i present; exception beats branch when both pulse same cycle, both in direct load and pending buffer.
- Undefined: ports absent; redir = br_valid_i, redir_pc = br_pc_i; behaviour otherwise identical.

## Structure
- Shared package: PC_W, RESET_PC default, FETCH_N, FSM state encoding, fetch-block byte-size and alignment-mask constants.
- One sub-module: preif_redirect_buf (priority mux plus pend_valid/pend_pc register, clear on acceptance).

## Test plan
- Reset, if_allowin_i=1, addr_ok tied 1, FETCH_N=1 -> requests 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles, drop=0.
- FETCH_N=4, branch to 0x1c000124 in STALL -> inst_addr_o=0x1c000120, preif_to_if_pc_o=0x1c000124, next request 0x1c000130.
- Request held 3 cycles (addr_ok low), branch to 0x1c000200 in wait cycle 1 -> address unchanged until accepted, handed with drop=1, next request 0x1c000200.
- Branch and exception same cycle with PREIF_EXCP_EN (excp 0x1c008000) -> next fetch 0x1c008000; without macro -> branch target.
- if_allowin_i falls during outstanding request -> req held until addr_ok, fetch handed, then STALL, no new request until allowin returns.
- fetch_pc=0xFFFFFFFC sequential -> next request 0x00000000; rst mid-request -> req low next cycle, restart at RESET_PC.
